// File: rtl/key_hit_decoder_pkg.sv
// Shared lane constants and the pending-vector priority helper for the key hit decoder.
package key_hit_decoder_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;

  typedef logic [LANE_W-1:0] lane_idx_t;
  typedef logic [LANES-1:0]  lane_vec_t;

  localparam lane_idx_t LANE_0 = 2'd0;
  localparam lane_idx_t LANE_1 = 2'd1;
  localparam lane_idx_t LANE_2 = 2'd2;
  localparam lane_idx_t LANE_3 = 2'd3;

  // Lowest set index wins; returns LANE_0 for an empty vector.
  function automatic lane_idx_t lowest_lane(input lane_vec_t vec);
    lane_idx_t idx;
    idx = LANE_0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = lane_idx_t'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One lane: two-flop synchroniser, stability counter, debounced level and press-edge pulse.
module key_debounce #(
  parameter int unsigned DebounceCycles = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_raw_i,
  output logic key_stable_o,
  output logic key_rise_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            stable_q, stable_d;
  logic            stable_dly_q, stable_dly_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d      = key_raw_i;
    sync2_d      = sync1_q;
    stable_dly_d = stable_q;
    stable_d     = stable_q;
    cnt_d        = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      // Level has differed for the full window: accept it.
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
    end
  end

  assign key_stable_o = stable_q;
  assign key_rise_o   = stable_q & ~stable_dly_q;

endmodule

// File: rtl/key_hit_decoder.sv
// Decodes the merged key vector into debounced, serialised per-lane hit events
// over a valid/ready handshake; lower lanes take priority.
module key_hit_decoder
  import key_hit_decoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANES-1:0]  keys_raw,
  output logic [LANES-1:0]  keys_stable,
  output logic              hit_valid,
  output logic [LANE_W-1:0] hit_lane,
  input  logic              hit_ready,
  output logic              overflow
);

  lane_vec_t stable;
  lane_vec_t rise;

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    key_debounce #(
      .DebounceCycles(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk_i       (clk),
      .rst_i       (rst),
      .key_raw_i   (keys_raw[g]),
      .key_stable_o(stable[g]),
      .key_rise_o  (rise[g])
    );
  end

  lane_vec_t pending_q, pending_d;
  logic      hit_valid_q, hit_valid_d;
  lane_idx_t hit_lane_q, hit_lane_d;
  logic      overflow_q, overflow_d;

  logic      out_free;
  logic      load;
  lane_idx_t load_lane;
  lane_vec_t clear_mask;

  always_comb begin
    out_free   = ~hit_valid_q | hit_ready;
    load       = out_free & (|pending_q);
    load_lane  = lowest_lane(pending_q);
    clear_mask = load ? (lane_vec_t'(1) << load_lane) : '0;
    // A rise in the same edge its bit is being loaded re-arms the bit instead of overflowing.
    pending_d  = (pending_q & ~clear_mask) | rise;
    overflow_d = |(rise & pending_q & ~clear_mask);

    hit_valid_d = hit_valid_q;
    hit_lane_d  = hit_lane_q;
    if (out_free) begin
      hit_valid_d = load;
      if (load) begin
        hit_lane_d = load_lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      hit_valid_q <= 1'b0;
      hit_lane_q  <= LANE_0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      hit_valid_q <= hit_valid_d;
      hit_lane_q  <= hit_lane_d;
      overflow_q  <= overflow_d;
    end
  end

  assign keys_stable = stable;
  assign hit_valid   = hit_valid_q;
  assign hit_lane    = hit_lane_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_key_hit_decoder.sv
// Directed bench for key_hit_decoder with a 4-cycle debounce window.
module tb_key_hit_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] keys_raw;
  logic [3:0] keys_stable;
  logic       hit_valid;
  logic [1:0] hit_lane;
  logic       hit_ready;
  logic       overflow;

  int n_checks;
  int n_errors;

  key_hit_decoder #(
    .DEBOUNCE_CYCLES(4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .keys_raw   (keys_raw),
    .keys_stable(keys_stable),
    .hit_valid  (hit_valid),
    .hit_lane   (hit_lane),
    .hit_ready  (hit_ready),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_eq({tag, "_valid"}, hit_valid, 0);
      check_eq({tag, "_ovf"}, overflow, 0);
    end
  endtask

  // Checks the presented event now, then advances one edge.
  task automatic expect_hit(input string tag, input logic [1:0] lane);
    check_eq({tag, "_valid"}, hit_valid, 1);
    check_eq({tag, "_lane"}, hit_lane, lane);
    step();
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    keys_raw  = 4'hF;
    hit_ready = 1'b1;

    // Reset and idle
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_valid", hit_valid, 0);
      check_eq("rst_stable", keys_stable, 0);
      check_eq("rst_lane", hit_lane, 0);
      check_eq("rst_ovf", overflow, 0);
    end
    rst = 1'b0;
    step();  // edge k
    for (int j = 0; j < 5; j++) begin
      check_eq("boot_stable_pre", keys_stable, 0);
      step();
    end
    check_eq("boot_stable", keys_stable, 4'hF);
    check_eq("boot_valid_k5", hit_valid, 0);
    step();
    check_eq("boot_valid_k6", hit_valid, 0);
    step();
    expect_hit("boot_h0", 2'd0);
    expect_hit("boot_h1", 2'd1);
    expect_hit("boot_h2", 2'd2);
    expect_hit("boot_h3", 2'd3);
    check_eq("boot_done", hit_valid, 0);
    keys_raw = 4'h0;
    idle_check("boot_rel", 8);
    check_eq("boot_rel_stable", keys_stable, 0);

    // Single press on lane 2
    keys_raw = 4'b0100;
    step();
    for (int j = 0; j < 5; j++) begin
      check_eq("single_stable_pre", keys_stable, 0);
      step();
    end
    check_eq("single_stable", keys_stable, 4'b0100);
    step();
    check_eq("single_valid_k6", hit_valid, 0);
    step();
    expect_hit("single_hit", 2'd2);
    check_eq("single_one_cycle", hit_valid, 0);
    idle_check("single_hold", 8);
    keys_raw = 4'h0;
    idle_check("single_rel", 8);
    check_eq("single_rel_stable", keys_stable, 0);

    // Glitch on lane 1: high for 3 sampled edges
    keys_raw = 4'b0010;
    steps(3);
    keys_raw = 4'h0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("glitch_stable", keys_stable, 0);
      check_eq("glitch_valid", hit_valid, 0);
      check_eq("glitch_ovf", overflow, 0);
    end

    // Simultaneous press with backpressure
    hit_ready = 1'b0;
    keys_raw  = 4'b1011;
    step();
    steps(6);
    check_eq("bp_valid_k6", hit_valid, 0);
    step();
    for (int s = 0; s < 10; s++) begin
      check_eq("bp_stall_valid", hit_valid, 1);
      check_eq("bp_stall_lane", hit_lane, 0);
      step();
    end
    hit_ready = 1'b1;
    expect_hit("bp_h0", 2'd0);
    expect_hit("bp_h1", 2'd1);
    expect_hit("bp_h3", 2'd3);
    check_eq("bp_done", hit_valid, 0);
    keys_raw = 4'h0;
    idle_check("bp_rel", 8);

    // Overflow on lane 3 while lane 0 is stalled
    hit_ready = 1'b0;
    keys_raw  = 4'b0001;
    steps(8);
    check_eq("ovf_l0_valid", hit_valid, 1);
    check_eq("ovf_l0_lane", hit_lane, 0);
    keys_raw = 4'b1001;
    steps(8);
    check_eq("ovf_first_press", overflow, 0);
    keys_raw = 4'b0001;
    steps(8);
    check_eq("ovf_released", keys_stable, 4'b0001);
    keys_raw = 4'b1001;
    step();  // edge k
    steps(5);
    check_eq("ovf_pre", overflow, 0);
    step();
    check_eq("ovf_pulse", overflow, 1);
    step();
    check_eq("ovf_post", overflow, 0);
    check_eq("ovf_hold_lane", hit_lane, 0);
    hit_ready = 1'b1;
    expect_hit("ovf_h0", 2'd0);
    expect_hit("ovf_h3", 2'd3);
    check_eq("ovf_done", hit_valid, 0);
    idle_check("ovf_idle", 4);
    keys_raw = 4'h0;
    idle_check("ovf_rel", 8);

    // Reset mid-operation with lanes 1,2 pending
    hit_ready = 1'b0;
    keys_raw  = 4'b0111;
    steps(8);
    check_eq("mid_valid", hit_valid, 1);
    check_eq("mid_lane", hit_lane, 0);
    rst      = 1'b1;
    keys_raw = 4'h0;
    step();
    check_eq("mid_rst_valid", hit_valid, 0);
    check_eq("mid_rst_stable", keys_stable, 0);
    check_eq("mid_rst_ovf", overflow, 0);
    rst       = 1'b0;
    hit_ready = 1'b1;
    idle_check("mid_after", 12);
    check_eq("mid_after_stable", keys_stable, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_hit_decoder.md
Name: key_hit_decoder

Overview:
- Inverse side of the lane-merge path: takes the 4-bit merged key vector (keyboard and board buttons OR'd together per lane) and decodes it into individual, debounced, one-at-a-time lane hit events.
- Sits between the key inputs and the judge/score logic.
- Provides synchronisation, per-lane debounce, press-edge detection, and priority serialisation over a valid/ready handshake.

Parameters:
- LANES, 4, number of lanes; fixed at 4 for this game.
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles needed to accept a level change. Range 2..2^20; the bench uses 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- keys_raw  input  4  merged raw key levels, asynchronous to clk; bit i is lane i.
- keys_stable  output  4  debounced key levels.
- hit_valid  output  1  a hit event is presented.
- hit_lane  output  2  lane index of the presented event.
- hit_ready  input  1  consumer accepts the event when high with hit_valid.
- overflow  output  1  one-cycle pulse; a press was dropped.

Behaviour:
- Reset: every register is cleared on a clk edge with rst=1. Outputs keys_stable=0, hit_valid=0, hit_lane=0, overflow=0. Synchronisers, counters and the pending vector are cleared.
- Reset mid-operation: any presented or pending event is discarded. A key still held after reset is re-debounced from stable=0 and produces a fresh press event.
- Synchroniser: two flops per lane on keys_raw; sync[i] is the second flop's output.
- Debounce, per lane:
  - The counter clears whenever sync[i]==keys_stable[i].
  - Otherwise it increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, keys_stable[i] toggles on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes keys_stable.
- Press detect: a rise of keys_stable[i] sets pending[i] on the following edge. Falls (releases) produce no event.
- Serialiser:
  - The output register is "free" when hit_valid=0, or when hit_valid=1 and hit_ready=1.
  - When free and pending≠0, load the lowest-index pending lane: hit_lane=that index, hit_valid=1, clear that pending bit.
  - When free and pending=0, hit_valid goes 0.
  - While hit_valid=1 and hit_ready=0, hit_valid and hit_lane hold unchanged.
- Back-to-back: with hit_ready held high, one event is accepted per cycle with no bubble.
- Latency: keys_raw[i] rises and stays high from edge k. Then:
  - keys_stable[i]=1 after edge k+1+DEBOUNCE_CYCLES.
  - pending[i] is set after edge k+2+DEBOUNCE_CYCLES.
  - hit_valid=1 after edge k+3+DEBOUNCE_CYCLES, if the output is free and no lower lane is pending.
- Collision rules:
  - A press on a lane whose pending bit is already set, and which is not being loaded this edge, is dropped. pending stays 1 and overflow pulses high for exactly 1 cycle.
  - A press on a lane in the same edge its pending bit is being loaded: the set wins, so pending stays 1 and no overflow.
  - Simultaneous presses on several lanes set all of their pending bits. They are then emitted in ascending lane order.
- Arithmetic: debounce counter width is $clog2(DEBOUNCE_CYCLES). No wrap is possible, because the counter clears at the terminal count.

Decomposition:
- Shared package/header holds: LANES=4, LANE_W=2, and lane index constants LANE_0..LANE_3.
- One natural sub-module, key_debounce: one lane's synchroniser, counter, stable flop and rise pulse. It is instantiated LANES times.
- The pending vector, priority encoder and output register stay in key_hit_decoder.

Test Plan:
- Reset and idle (DEBOUNCE_CYCLES=4): assert rst for 3 cycles with keys_raw=4'b1111, then release rst. During reset all outputs are 0. keys_stable=4'b1111 exactly 5 edges after rst drops; four hits follow in order lanes 0,1,2,3.
- Single press: keys_raw[2] 0->1 at edge k, hit_ready=1. keys_stable=4'b0100 after edge k+5; hit_valid=1 with hit_lane=2 for exactly 1 cycle, after edge k+7. Holding the key or releasing it gives no further hit.
- Glitch rejection: keys_raw[1] pulses high for 3 cycles, then low. keys_stable stays 0, hit_valid is never asserted, overflow stays 0.
- Simultaneous press and backpressure: keys_raw 0->4'b1011, hit_ready=0 for 10 cycles, then 1. hit_valid holds with hit_lane=0 throughout the stall. After hit_ready=1, lanes 0,1,3 are emitted on consecutive cycles, then hit_valid=0.
- Overflow: press and release lane 3, keeping hit_ready=0 with lane 0 already presented, then press lane 3 again. Lane 3 stays pending and overflow is high for exactly 1 cycle. After the stall, lanes 0 and 3 are emitted once each.
- Reset mid-operation: rst=1 for 1 cycle while hit_valid=1 and pending=4'b0110, keys released. Next cycle hit_valid=0 and keys_stable=0, and no stale event is ever emitted.
